rvv_vd_writeback: RTL and testbench

RVV_VD_WRITEBACK -- requirements
Module: rvv_vd_writeback

---
 rtl/rvv_vd_writeback.sv | 237 +++++++++++++++++++++++
 tb/tb_rvv_vd_writeback.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_vd_writeback.sv
// Vector destination write-back assembler.
// Collects per-lane ALU results into a VLEN-wide destination image that starts
// from the register's prior contents, then hands each completed register of the
// LMUL group to the register file through a valid/ready write port.
module rvv_vd_writeback #(
   parameter logic [16:0] VLEN     = 17'd128,
   parameter int          NB_LANES = 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         start,
   input  logic [2:0]                   vsew,
   input  logic [16:0]                  vl,
   input  logic                         mask_en,
   input  logic [VLEN-1:0]              v0,
   input  logic [VLEN-1:0]              old_vd,
   input  logic [(1<<NB_LANES)-1:0]     lane_valid,
   input  logic [(64<<NB_LANES)-1:0]    lane_data,
   input  logic [(17<<NB_LANES)-1:0]    lane_index,
   input  logic                         alu_done,
   output logic                         alu_stall,
   output logic                         wb_valid,
   input  logic                         wb_ready,
   output logic [VLEN-1:0]              wb_data,
   output logic [2:0]                   wb_reg_offset,
   output logic                         busy
);

   localparam int VW   = int'(VLEN);
   localparam int L    = 1 << NB_LANES;
   localparam int LOGV = $clog2(VW);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COLLECT = 2'd2,
      FLUSH   = 2'd3
   } state_t;

   state_t           state;
   logic [1:0]       latched_sew;
   logic [16:0]      latched_vl;
   logic             latched_mask;
   logic             final_flag;
   logic             load_stall;
   logic             pend_valid;
   logic [L-1:0]     pend_lv;
   logic [64*L-1:0]  pend_ld;
   logic [17*L-1:0]  pend_li;
   logic             divert;
   logic             pend_beyond;

   // Register (within the LMUL group) that holds global element idx.
   function automatic logic [16:0] reg_of(input logic [16:0] idx, input logic [1:0] sew);
      return idx >> (LOGV - 3 - int'(sew));
   endfunction

   // A lane takes part only when it is valid and addresses an active element.
   function automatic logic lane_active(input logic v, input logic [16:0] idx,
                                        input logic [16:0] vlim);
      return v && (idx < vlim);
   endfunction

   // True when any active lane targets a register past the current window.
   function automatic logic beyond_window(input logic [L-1:0] lv, input logic [17*L-1:0] li,
                                          input logic [1:0] sew, input logic [16:0] vlim,
                                          input logic [2:0] offs);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < L; i++) begin
         if (lane_active(lv[i], li[17*i +: 17], vlim) &&
             (reg_of(li[17*i +: 17], sew) > {14'd0, offs})) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   // Writes every unmasked, active, in-window lane of a beat into its slot;
   // all other slots keep what base already holds.
   function automatic logic [VLEN-1:0] merge_beat(
      input logic [VLEN-1:0]  base,
      input logic [L-1:0]     lv,
      input logic [64*L-1:0]  ld,
      input logic [17*L-1:0]  li,
      input logic [1:0]       sew,
      input logic [16:0]      vlim,
      input logic             msk,
      input logic [VLEN-1:0]  mbits,
      input logic [2:0]       offs
   );
      logic [VLEN-1:0] acc;
      logic [VLEN-1:0] wmask;
      logic [VLEN-1:0] wdata;
      logic [63:0]     dmask;
      logic [16:0]     idx;
      logic [16:0]     slot;
      logic [16:0]     pos;
      logic            mbit;
      int              sh;
      acc   = base;
      sh    = LOGV - 3 - int'(sew);
      dmask = (sew == 2'd3) ? {64{1'b1}} : ((64'd1 << (7'd8 << sew)) - 64'd1);
      for (int i = 0; i < L; i++) begin
         idx   = li[17*i +: 17];
         mbit  = (idx < VLEN) ? mbits[idx[LOGV-1:0]] : 1'b0;
         slot  = idx - (reg_of(idx, sew) << sh);
         pos   = slot << ({1'b0, sew} + 3'd3);
         wmask = VW'(dmask) << pos;
         wdata = VW'(ld[64*i +: 64] & dmask) << pos;
         if (lane_active(lv[i], idx, vlim) && (reg_of(idx, sew) == {14'd0, offs}) &&
             (!msk || mbit)) begin
            acc = (acc & ~wmask) | wdata;
         end
      end
      return acc;
   endfunction

   // Detect a beat that belongs to a later register, and a saved beat that still does.
   always_comb begin
      divert      = 1'b0;
      pend_beyond = 1'b0;
      if (state == COLLECT) begin
         divert = beyond_window(lane_valid, lane_index, latched_sew, latched_vl, wb_reg_offset);
      end else begin
         divert = 1'b0;
      end
      if (pend_valid) begin
         pend_beyond = beyond_window(pend_lv, pend_li, latched_sew, latched_vl, wb_reg_offset);
      end else begin
         pend_beyond = 1'b0;
      end
   end

   assign alu_stall = load_stall | divert;
   assign busy      = (state != IDLE);

   // Instruction sequencer: load prior contents, collect beats, flush each register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         latched_sew   <= 2'd0;
         latched_vl    <= 17'd0;
         latched_mask  <= 1'b0;
         final_flag    <= 1'b0;
         load_stall    <= 1'b0;
         pend_valid    <= 1'b0;
         pend_lv       <= '0;
         pend_ld       <= '0;
         pend_li       <= '0;
         wb_valid      <= 1'b0;
         wb_data       <= '0;
         wb_reg_offset <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               wb_valid <= 1'b0;
               if (start) begin
                  // Element widths above 64 bits are not supported; clamp to 64.
                  latched_sew   <= (vsew > 3'd3) ? 2'd3 : vsew[1:0];
                  latched_vl    <= vl;
                  latched_mask  <= mask_en;
                  wb_reg_offset <= 3'd0;
                  final_flag    <= 1'b0;
                  pend_valid    <= 1'b0;
                  load_stall    <= 1'b1;
                  state         <= LOAD;
               end else begin
                  load_stall <= 1'b0;
               end
            end
            LOAD: begin
               if (latched_vl == 17'd0) begin
                  wb_data    <= old_vd;
                  final_flag <= 1'b1;
                  wb_valid   <= 1'b1;
                  state      <= FLUSH;
               end else if (pend_beyond) begin
                  // Saved beat skips this register entirely: write it back untouched.
                  wb_data    <= old_vd;
                  final_flag <= 1'b0;
                  wb_valid   <= 1'b1;
                  state      <= FLUSH;
               end else begin
                  wb_data    <= merge_beat(old_vd, pend_lv & {L{pend_valid}}, pend_ld, pend_li,
                                           latched_sew, latched_vl, latched_mask, v0, wb_reg_offset);
                  pend_valid <= 1'b0;
                  load_stall <= 1'b0;
                  state      <= COLLECT;
               end
            end
            COLLECT: begin
               wb_data <= merge_beat(wb_data, lane_valid, lane_data, lane_index,
                                     latched_sew, latched_vl, latched_mask, v0, wb_reg_offset);
               if (divert) begin
                  pend_valid <= 1'b1;
                  pend_lv    <= lane_valid;
                  pend_ld    <= lane_data;
                  pend_li    <= lane_index;
                  final_flag <= 1'b0;
                  wb_valid   <= 1'b1;
                  load_stall <= 1'b1;
                  state      <= FLUSH;
               end else if (alu_done) begin
                  final_flag <= 1'b1;
                  wb_valid   <= 1'b1;
                  load_stall <= 1'b1;
                  state      <= FLUSH;
               end else begin
                  state <= COLLECT;
               end
            end
            FLUSH: begin
               if (wb_ready) begin
                  wb_valid <= 1'b0;
                  if (final_flag) begin
                     load_stall <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     wb_reg_offset <= wb_reg_offset + 3'd1;
                     load_stall    <= 1'b1;
                     state         <= LOAD;
                  end
               end else begin
                  state <= FLUSH;
               end
            end
            default: begin
               wb_valid   <= 1'b0;
               load_stall <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rvv_vd_writeback.sv
// Bench for rvv_vd_writeback: an element-level model predicts every register
// write; a monitor thread compares each accepted write and hold-stability, and
// directed tests add literal expectations.
module tb_rvv_vd_writeback;

   localparam int VLEN = 128;
   localparam int L    = 2;

   logic              clk = 1'b0;
   logic              resetn = 1'b1;
   logic              start = 1'b0;
   logic [2:0]        vsew = 3'd0;
   logic [16:0]       vl = 17'd0;
   logic              mask_en = 1'b0;
   logic [VLEN-1:0]   v0 = '0;
   logic [VLEN-1:0]   old_vd;
   logic [L-1:0]      lane_valid = '0;
   logic [64*L-1:0]   lane_data = '0;
   logic [17*L-1:0]   lane_index = '0;
   logic              alu_done = 1'b0;
   logic              alu_stall;
   logic              wb_valid;
   logic              wb_ready = 1'b1;
   logic [VLEN-1:0]   wb_data;
   logic [2:0]        wb_reg_offset;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [16:0] bi [8][L];
   logic [63:0] bd [8][L];
   bit          bv [8][L];
   int          nb;

   logic [VLEN-1:0] exp_d [$];
   logic [2:0]      exp_o [$];
   logic [VLEN-1:0] cap_d [$];
   logic [2:0]      cap_o [$];

   rvv_vd_writeback #(.VLEN(17'd128), .NB_LANES(1)) dut (
      .clk(clk), .resetn(resetn), .start(start), .vsew(vsew), .vl(vl),
      .mask_en(mask_en), .v0(v0), .old_vd(old_vd), .lane_valid(lane_valid),
      .lane_data(lane_data), .lane_index(lane_index), .alu_done(alu_done),
      .alu_stall(alu_stall), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_data(wb_data), .wb_reg_offset(wb_reg_offset), .busy(busy)
   );

   always #5 clk = ~clk;

   // Prior register contents: register r is filled with byte 0xAA + 0x11*r.
   function automatic logic [VLEN-1:0] old_of(input int r);
      logic [7:0] b;
      b = 8'hAA + 8'(17 * r);
      return {16{b}};
   endfunction

   assign old_vd = old_of(int'(wb_reg_offset));

   task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_beat(input int k, input int i0, input logic [63:0] d0, input bit e0,
                           input int i1, input logic [63:0] d1, input bit e1);
      bi[k][0] = 17'(i0); bd[k][0] = d0; bv[k][0] = e0;
      bi[k][1] = 17'(i1); bd[k][1] = d1; bv[k][1] = e1;
   endtask

   // Element-level model: which element values survive, then which registers get written.
   task automatic model(input int sew, input int vlv, input bit m, input logic [VLEN-1:0] v0v);
      int sewb, epr, maxreg, e;
      logic [63:0] val [int];
      logic [VLEN-1:0] d;
      sewb = 8 << sew;
      epr = VLEN / sewb;
      maxreg = 0;
      for (int k = 0; k < nb; k++) begin
         for (int l = 0; l < L; l++) begin
            e = int'(bi[k][l]);
            if (bv[k][l] && e < vlv) begin
               if (e / epr > maxreg) maxreg = e / epr;
               if (!m || v0v[e]) val[e] = bd[k][l];
            end
         end
      end
      for (int r = 0; r <= maxreg; r++) begin
         d = old_of(r);
         for (int s = 0; s < epr; s++) begin
            e = r * epr + s;
            if (val.exists(e)) begin
               for (int b = 0; b < sewb; b++) d[s*sewb + b] = val[e][b];
            end
         end
         exp_d.push_back(d);
         exp_o.push_back(3'(r));
      end
   endtask

   // Checks every accepted write against the model and stability while held.
   task automatic monitor();
      bit pv, pr;
      logic [VLEN-1:0] pd;
      logic [2:0] po;
      pv = 1'b0; pr = 1'b0; pd = '0; po = 3'd0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               chk("hold_valid", wb_valid, 1);
               chk("hold_data", wb_data, pd);
               chk("hold_offset", wb_reg_offset, po);
               chk("hold_stall", alu_stall, 1);
            end
            if (wb_valid && wb_ready) begin
               chk("write_expected", exp_d.size() != 0, 1);
               if (exp_d.size() != 0) begin
                  chk("write_data", wb_data, exp_d.pop_front());
                  chk("write_offset", wb_reg_offset, exp_o.pop_front());
               end
               cap_d.push_back(wb_data);
               cap_o.push_back(wb_reg_offset);
            end
            pv = wb_valid; pr = wb_ready; pd = wb_data; po = wb_reg_offset;
         end
      end
   endtask

   // Runs one instruction: start pulse, beats with stall handshake, wait for idle.
   task automatic run(input int sew, input int vlv, input bit m, input logic [VLEN-1:0] v0v);
      int t;
      cap_d.delete();
      cap_o.delete();
      model(sew, vlv, m, v0v);
      @(posedge clk); #1;
      vsew = 3'(sew); vl = 17'(vlv); mask_en = m; v0 = v0v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < nb; k++) begin
         lane_valid = {bv[k][1], bv[k][0]};
         lane_data  = {bd[k][1], bd[k][0]};
         lane_index = {bi[k][1], bi[k][0]};
         alu_done   = (k == nb - 1);
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while ((alu_stall || !busy) && t < 300);
         if (t >= 300) chk("beat_timeout", t, 0);
         @(posedge clk); #1;
      end
      lane_valid = '0;
      t = 0;
      while (busy && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("idle_timeout", busy, 0);
      alu_done = 1'b0;
      chk("all_writes_seen", exp_d.size(), 0);
      exp_d.delete();
      exp_o.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      fork
         monitor();
      join_none

      // Reset state
      #2 resetn = 1'b0;
      #10;
      chk("rst_busy", busy, 0);
      chk("rst_valid", wb_valid, 0);
      chk("rst_stall", alu_stall, 0);
      chk("rst_data", wb_data, '0);
      chk("rst_offset", wb_reg_offset, 0);
      @(posedge clk); #2 resetn = 1'b1;

      // Four 32-bit elements in two beats; upper lane bits are junk
      nb = 2;
      set_beat(0, 0, 64'hFFFFFFFF_00000001, 1, 1, 64'hFFFFFFFF_00000002, 1);
      set_beat(1, 2, 64'hFFFFFFFF_00000003, 1, 3, 64'hFFFFFFFF_00000004, 1);
      run(2, 4, 0, '0);
      chk("t037_nwrites", cap_d.size(), 1);
      chk("t037_data", cap_d[0], 128'h00000004_00000003_00000002_00000001);
      chk("t037_offset", cap_o[0], 0);

      // Tail element beyond vl stays undisturbed
      run(2, 3, 0, '0);
      chk("t038_data", cap_d[0], 128'hAAAAAAAA_00000003_00000002_00000001);

      // Beat crossing into the next register
      nb = 3;
      set_beat(2, 4, 64'h5, 1, 5, 64'h6, 1);
      run(2, 6, 0, '0);
      chk("t039_nwrites", cap_d.size(), 2);
      chk("t039_data0", cap_d[0], 128'h00000004_00000003_00000002_00000001);
      chk("t039_off1", cap_o[1], 1);
      chk("t039_data1", cap_d[1], 128'hBBBBBBBB_BBBBBBBB_00000006_00000005);

      // Byte elements under v0 masking
      nb = 2;
      set_beat(0, 0, 64'h11, 1, 1, 64'h22, 1);
      set_beat(1, 2, 64'h33, 1, 3, 64'h44, 1);
      run(0, 4, 1, 128'b0101);
      chk("t040_data", cap_d[0], 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AA33AA11);

      // Invalid lane ignored, 64-bit elements
      nb = 1;
      set_beat(0, 0, 64'h11112222_33334444, 1, 1, 64'h55556666_77778888, 0);
      run(3, 2, 0, '0);
      chk("t032_data", cap_d[0], 128'hAAAAAAAA_AAAAAAAA_11112222_33334444);

      // vl = 0 writes the old register once
      nb = 0;
      run(2, 0, 0, '0);
      chk("t033_nwrites", cap_d.size(), 1);
      chk("t033_data", cap_d[0], {16{8'hAA}});

      // Write port back-pressure with a stray start during FLUSH
      nb = 2;
      set_beat(0, 0, 64'h1, 1, 1, 64'h2, 1);
      set_beat(1, 2, 64'h3, 1, 3, 64'h4, 1);
      wb_ready = 1'b0;
      fork
         run(2, 4, 0, '0);
         begin
            int t;
            t = 0;
            while (!wb_valid && t < 300) begin
               @(negedge clk);
               t++;
            end
            chk("t041_reach_flush", wb_valid, 1);
            @(posedge clk); #1 start = 1'b1; vl = 17'd1;
            @(posedge clk); #1 start = 1'b0;
            repeat (3) @(posedge clk);
            #1 wb_ready = 1'b1;
         end
      join
      chk("t041_nwrites", cap_d.size(), 1);
      chk("t041_data", cap_d[0], 128'h00000004_00000003_00000002_00000001);
      repeat (3) @(negedge clk);
      chk("t034_stays_idle", busy, 0);

      // Asynchronous reset in COLLECT
      @(posedge clk); #1 vsew = 3'd2; vl = 17'd4; mask_en = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lane_valid = 2'b11; lane_data = {64'h2, 64'h1}; lane_index = {17'd1, 17'd0};
      @(posedge clk); #2;
      chk("t042_in_collect", busy & ~alu_stall, 1);
      #1 resetn = 1'b0;
      #1;
      chk("t042_busy", busy, 0);
      chk("t042_valid", wb_valid, 0);
      chk("t042_stall", alu_stall, 0);
      chk("t042_data", wb_data, '0);
      chk("t042_offset", wb_reg_offset, 0);
      lane_valid = '0;
      @(posedge clk); #2 resetn = 1'b1;
      run(2, 4, 0, '0);
      chk("t042_after_data", cap_d[0], 128'h00000004_00000003_00000002_00000001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
